vga_fb_flip_ctrl: RTL
=====================

// Module: vga_fb_flip_ctrl
// PURPOSE
//   Frame-buffer flip controller for the VGA display pipe. Issues single AXI4-Lite writes to the
//   VGA controller's frame-base register on the control bus: one boot write of FB0_BASE after reset,
//   then one write per accepted flip request. Tracks the active base, counts completed flips and
//   flags slave errors. Sits between the CPU-side flip request source and the VGA controller's slave port.
// PARAMETERS
//   FB_REG_ADDR   32'h1D00_0000  byte address of the VGA controller frame-base register
//   FB0_BASE      32'h0F00_0000  frame base written by the boot write
//   CNT_W         16             width of flip_cnt (wraps)
// PORTS
//   aclk          in   1    clock (sole clock domain)
//   areset        in   1    synchronous reset, active-high
//   req_valid     in   1    flip request valid
//   req_base      in   32   new frame base; low 2 bits ignored (forced 0 on the bus)
//   req_ready     out  1    request accepted when req_valid && req_ready
//   m_awaddr      out  32   AXI-Lite write address (always FB_REG_ADDR)
//   m_awvalid     out  1
//   m_awready     in   1
//   m_wdata       out  32   base being written
//   m_wstrb       out  4    always 4'hF
//   m_wvalid      out  1
//   m_wready      in   1
//   m_bresp       in   2
//   m_bvalid      in   1
//   m_bready      out  1
//   m_ar*/m_r*    AXI-Lite read channel (araddr 32 out, arvalid out, arready in, rdata 32 in,
//                 rresp 2 in, rvalid in, rready out); tied idle (0) without VGA_FB_READBACK_EN
//   cur_base      out  32   last successfully written base
//   flip_done     out  1    one-cycle pulse when a flip (not the boot write) completes
//   flip_cnt      out  CNT_W count of completed flips, OKAY and error alike, wraps to 0
//   err           out  1    sticky: set on non-OKAY response (or readback mismatch); cleared by reset only
// BEHAVIOUR
//   Reset: state BOOT; all valid/ready outputs 0; cur_base=0, flip_cnt=0, err=0, flip_done=0.
//   States: BOOT -> WR -> RESP [-> RD -> RDAT] -> IDLE -> WR ...
//   BOOT: one cycle after reset release, loads wdata=FB0_BASE, enters WR. req_ready=0.
//   IDLE: req_ready=1 (combinational from state only, never from req_valid). On accept, latch
//     req_base&~3 into wdata, enter WR. req_ready=0 in every other state.
//   WR: awvalid and wvalid asserted together on entry; each drops the cycle after its own handshake;
//     AW and W may complete in either order or the same cycle; leave for RESP once both are done.
//     awaddr/wdata stable while valid.
//   RESP: bready=1. On bvalid: bresp==OKAY -> cur_base<=wdata; else err<=1, cur_base unchanged.
//     Next: RD if readback enabled, else IDLE. flip_done pulses and flip_cnt increments in the
//     cycle entering IDLE from a flip (never for the boot write).
//   A request held while busy is accepted in the first IDLE cycle; minimum accept-to-accept spacing
//     = 3 cycles with zero-wait slave (WR, RESP, IDLE).
//   flip_cnt at all-ones wraps to 0 on the next completed flip.
//   Reset mid-transaction: abandon immediately, return to BOOT; the slave shares this reset.
// CONFIGURATION
//   VGA_FB_READBACK_EN defined: after an OKAY write, RD issues arvalid at FB_REG_ADDR until arready,
//     RDAT holds rready=1 until rvalid; rresp!=OKAY or rdata!=wdata sets err. flip_done then
//     fires on leaving RDAT. Not defined: read channel outputs constant 0, RESP goes straight to IDLE.
// STRUCTURE
//   vga_pkg: fb_flip_state_e enum (BOOT, IDLE, WR, RESP, RD, RDAT); AXI_RESP_OKAY/SLVERR/DECERR
//   2-bit constants. Single module, no sub-module; AW/W done flags are local registers.
// TESTING
//   1 Reset release, zero-wait slave: one write of 32'h0F00_0000 to FB_REG_ADDR; cur_base=0F00_0000,
//     no flip_done, flip_cnt=0.
//   2 req_base=32'h0F10_0003, zero-wait: wdata=0F10_0000, flip_done one cycle, flip_cnt=1, req_ready
//     low 2 cycles between back-to-back accepts.
//   3 awready 3 cycles before wready (and reverse, and same cycle): exactly one AW and one W beat, no
//     valid drop before handshake.
//   4 bresp=2'b10: err=1 sticky, cur_base unchanged, flip_cnt still increments; next OKAY flip does not clear err.
//   5 Assert areset while WR awaiting wready: outputs 0 next cycle, boot write reissued after release.
//   6 READBACK_EN, rdata=wdata^1: err=1, flip_done after RDAT; 2^CNT_W flips -> flip_cnt back to 0.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared state encoding and AXI response codes for the VGA frame-buffer flip controller.
package vga_pkg;

    typedef enum logic [2:0] {BOOT, IDLE, WR, RESP, RD, RDAT} fb_flip_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/vga_fb_flip_ctrl.sv
// vga_fb_flip_ctrl: issues AXI4-Lite frame-base writes (boot write, then one per flip request).
// Define VGA_FB_READBACK_EN to verify each OKAY write with a read of the same register.
module vga_fb_flip_ctrl
    import vga_pkg::*;
#(
    parameter logic [31:0] FB_REG_ADDR = 32'h1D00_0000,
    parameter logic [31:0] FB0_BASE    = 32'h0F00_0000,
    parameter int          CNT_W       = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             req_valid,
    input  logic [31:0]      req_base,
    output logic             req_ready,
    output logic [31:0]      m_awaddr,
    output logic             m_awvalid,
    input  logic             m_awready,
    output logic [31:0]      m_wdata,
    output logic [3:0]       m_wstrb,
    output logic             m_wvalid,
    input  logic             m_wready,
    input  logic [1:0]       m_bresp,
    input  logic             m_bvalid,
    output logic             m_bready,
    output logic [31:0]      m_araddr,
    output logic             m_arvalid,
    input  logic             m_arready,
    input  logic [31:0]      m_rdata,
    input  logic [1:0]       m_rresp,
    input  logic             m_rvalid,
    output logic             m_rready,
    output logic [31:0]      cur_base,
    output logic             flip_done,
    output logic [CNT_W-1:0] flip_cnt,
    output logic             err
);

    fb_flip_state_e   state_q;
    logic [31:0]      wdata_q, cur_base_q;
    logic             awvalid_q, wvalid_q, bready_q, aw_done_q, w_done_q;
    logic             is_flip_q, flip_done_q, err_q;
    logic [CNT_W-1:0] flip_cnt_q, flip_cnt_d;
    logic             aw_hs, w_hs, wr_done;

    assign aw_hs      = awvalid_q && m_awready;
    assign w_hs       = wvalid_q && m_wready;
    assign wr_done    = (aw_done_q || aw_hs) && (w_done_q || w_hs);
    assign flip_cnt_d = is_flip_q ? flip_cnt_q + CNT_W'(1) : flip_cnt_q;

    assign req_ready = state_q == IDLE;
    assign m_awaddr  = FB_REG_ADDR;
    assign m_awvalid = awvalid_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = 4'hF;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
    assign cur_base  = cur_base_q;
    assign flip_done = flip_done_q;
    assign flip_cnt  = flip_cnt_q;
    assign err       = err_q;

`ifdef VGA_FB_READBACK_EN
    logic arvalid_q, rready_q;
    assign m_araddr  = FB_REG_ADDR;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;
`else
    logic unused_rd;
    assign unused_rd = ^{m_arready, m_rdata, m_rresp, m_rvalid};
    assign m_araddr  = 32'h0;
    assign m_arvalid = 1'b0;
    assign m_rready  = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= BOOT;
            wdata_q     <= 32'h0;
            cur_base_q  <= 32'h0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            is_flip_q   <= 1'b0;
            flip_done_q <= 1'b0;
            err_q       <= 1'b0;
            flip_cnt_q  <= '0;
`ifdef VGA_FB_READBACK_EN
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
`endif
        end else begin
            flip_done_q <= 1'b0;
            case (state_q)
                BOOT: begin
                    wdata_q   <= FB0_BASE;
                    is_flip_q <= 1'b0;
                    awvalid_q <= 1'b1;
                    wvalid_q  <= 1'b1;
                    state_q   <= WR;
                end
                IDLE: if (req_valid) begin
                    wdata_q   <= req_base & ~32'h3;
                    is_flip_q <= 1'b1;
                    awvalid_q <= 1'b1;
                    wvalid_q  <= 1'b1;
                    state_q   <= WR;
                end
                WR: begin
                    // AW and W retire independently; done flags remember the earlier one
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (wr_done) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                RESP: if (m_bvalid) begin
                    bready_q <= 1'b0;
                    if (m_bresp == AXI_RESP_OKAY) cur_base_q <= wdata_q;
                    else err_q <= 1'b1;
`ifdef VGA_FB_READBACK_EN
                    if (m_bresp == AXI_RESP_OKAY) begin
                        arvalid_q <= 1'b1;
                        state_q   <= RD;
                    end else begin
                        flip_done_q <= is_flip_q;
                        flip_cnt_q  <= flip_cnt_d;
                        state_q     <= IDLE;
                    end
`else
                    flip_done_q <= is_flip_q;
                    flip_cnt_q  <= flip_cnt_d;
                    state_q     <= IDLE;
`endif
                end
`ifdef VGA_FB_READBACK_EN
                RD: if (m_arready) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state_q   <= RDAT;
                end
                RDAT: if (m_rvalid) begin
                    rready_q <= 1'b0;
                    if (m_rresp != AXI_RESP_OKAY || m_rdata != wdata_q) err_q <= 1'b1;
                    flip_done_q <= is_flip_q;
                    flip_cnt_q  <= flip_cnt_d;
                    state_q     <= IDLE;
                end
`endif
                default: state_q <= BOOT;
            endcase
        end
    end

endmodule
